// File: rtl/datapath_ctrl.sv
// datapath_ctrl: three-state instruction sequencer (IDLE -> EXEC -> WB).
// Latches one 32-bit instruction word per handshake and drives it to the
// datapath. It waits ALU_LAT unstalled EXEC cycles, then issues the write
// enables for one unstalled WB cycle. A Y1/Y2 dual-write collision is
// resolved in favour of Y1 and reported on err_dual.
module datapath_ctrl #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        stall,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  Y1,
  output logic [3:0]  Y2,
  output logic [1:0]  write,
  output logic        busy,
  output logic        err_dual,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // The counter counts down to zero, so EXEC lasts ALU_LAT unstalled cycles.
  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] word_r;
  logic [15:0] retired_r;

  // A write field of 11 that targets the same register twice is a collision.
  function automatic logic dual_collision(input logic [31:0] word);
    return (word[1:0] == 2'b11) && (word[9:6] == word[5:2]);
  endfunction

  // Sequencer: state, cycle counter, latched instruction and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      word_r    <= 32'd0;
      retired_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid && !stall) begin
            word_r  <= instr;
            cnt_r   <= CNT_LOAD;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            if (cnt_r == 4'd0) begin
              state_r <= ST_WB;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
        end
        ST_WB: begin
          if (!stall) begin
            retired_r <= retired_r + 16'd1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Handshake readiness, write enables and collision flag for this cycle.
  always_comb begin
    instr_ready = 1'b0;
    write       = 2'b00;
    err_dual    = 1'b0;
    if (state_r == ST_IDLE) begin
      // Gated by rst_n so the controller never advertises readiness in reset.
      instr_ready = rst_n & ~stall;
    end else begin
      instr_ready = 1'b0;
    end
    if ((state_r == ST_WB) && !stall) begin
      if (dual_collision(word_r)) begin
        write    = 2'b01;
        err_dual = 1'b1;
      end else begin
        write    = word_r[1:0];
        err_dual = 1'b0;
      end
    end else begin
      write    = 2'b00;
      err_dual = 1'b0;
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign retired = retired_r;
  assign op      = word_r[31:29];
  assign form    = word_r[28];
  assign vec     = word_r[27:26];
  assign A       = word_r[25:22];
  assign B       = word_r[21:18];
  assign C       = word_r[17:14];
  assign D       = word_r[13:10];
  assign Y1      = word_r[9:6];
  assign Y2      = word_r[5:2];

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: table vectors, directed corner sequences and randomized
// traffic for datapath_ctrl. A transaction-level reference model counts
// unstalled cycles per accepted instruction and checks every cycle.
module tb_datapath_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        stall;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D, Y1, Y2;
  logic [1:0]  write;
  logic        busy;
  logic        err_dual;
  logic [15:0] retired;
  logic [29:0] fld_s;

  assign fld_s = {op, form, vec, A, B, C, D, Y1, Y2};

  datapath_ctrl #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .stall(stall), .op(op), .form(form), .vec(vec),
    .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2), .write(write),
    .busy(busy), .err_dual(err_dual), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: instruction in flight, unstalled cycles spent on it.
  bit          m_busy;
  int          m_prog;
  logic [31:0] m_word;
  logic [15:0] m_ret;

  // Observed DUT events, tagged with the cycle index.
  int          hs_q[$];
  int          wr_cyc_q[$];
  logic [1:0]  wr_val_q[$];
  int          err_q[$];

  typedef struct {
    bit          valid;
    bit          stl;
    logic [31:0] word;
    bit          e_ready;
    bit          e_busy;
    logic [1:0]  e_write;
    logic [2:0]  e_op;
    logic [3:0]  e_y1;
    logic [15:0] e_ret;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_prog = 0;
    m_word = 32'd0;
    m_ret  = 16'd0;
  endtask

  task automatic model_compare();
    bit         wb;
    logic [1:0] ew;
    logic       ee;
    wb = m_busy && (m_prog == LAT);
    ew = 2'b00;
    ee = 1'b0;
    if (rst_n && wb && !stall) begin
      if (m_word[1:0] == 2'b11 && m_word[9:6] == m_word[5:2]) begin
        ew = 2'b01;
        ee = 1'b1;
      end else begin
        ew = m_word[1:0];
      end
    end
    chk("ready",    {31'd0, instr_ready}, {31'd0, (rst_n === 1'b1) && !m_busy && !stall});
    chk("busy",     {31'd0, busy}, {31'd0, m_busy});
    chk("write",    {30'd0, write}, {30'd0, ew});
    chk("err_dual", {31'd0, err_dual}, {31'd0, ee});
    chk("fields",   {2'b00, fld_s}, {2'b00, m_word[31:2]});
    chk("retired",  {16'd0, retired}, {16'd0, m_ret});
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (instr_valid && !stall) begin
        m_busy = 1'b1;
        m_prog = 0;
        m_word = instr;
      end
    end else if (!stall) begin
      if (m_prog == LAT) begin
        m_busy = 1'b0;
        m_ret  = m_ret + 16'd1;
      end else begin
        m_prog++;
      end
    end
  endtask

  task automatic half_check();
    @(negedge clk);
    model_compare();
    if (instr_valid && instr_ready) hs_q.push_back(cyc);
    if (write != 2'b00) begin
      wr_cyc_q.push_back(cyc);
      wr_val_q.push_back(write);
    end
    if (err_dual) err_q.push_back(cyc);
  endtask

  task automatic half_step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic tick();
    half_check();
    half_step();
  endtask

  function automatic logic [31:0] mk(input logic [3:0] y1, input logic [3:0] y2, input logic [1:0] wr);
    logic [31:0] w;
    w = $urandom;
    w[9:6] = y1;
    w[5:2] = y2;
    w[1:0] = wr;
    return w;
  endfunction

  // Issue one instruction from IDLE and run it through WB; h = handshake cycle.
  task automatic run_instr(input logic [31:0] w, output int h);
    instr_valid = 1'b1;
    instr       = w;
    h           = cyc;
    tick();
    instr_valid = 1'b0;
    instr       = $urandom;
    repeat (LAT + 1) tick();
  endtask

  initial begin
    int h;
    int nw;
    int ne;
    int nh;
    logic [15:0] r0;

    rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; instr = 32'd0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;

    // First instruction straight out of reset: timing of each cycle.
    tbl[0] = '{1'b1, 1'b0, 32'h2A4C_8C8D, 1'b1, 1'b0, 2'b00, 3'd0, 4'd0, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 3'd1, 4'd2, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b00, 3'd1, 4'd2, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 2'b01, 3'd1, 4'd2, 16'd0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 2'b00, 3'd1, 4'd2, 16'd1};
    for (int i = 0; i < 5; i++) begin
      instr_valid = tbl[i].valid;
      stall       = tbl[i].stl;
      instr       = tbl[i].word;
      @(negedge clk);
      chk("tbl_ready",   {31'd0, instr_ready}, {31'd0, tbl[i].e_ready});
      chk("tbl_busy",    {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk("tbl_write",   {30'd0, write}, {30'd0, tbl[i].e_write});
      chk("tbl_op",      {29'd0, op}, {29'd0, tbl[i].e_op});
      chk("tbl_y1",      {28'd0, Y1}, {28'd0, tbl[i].e_y1});
      chk("tbl_retired", {16'd0, retired}, {16'd0, tbl[i].e_ret});
      model_compare();
      half_step();
    end

    // Back-to-back: valid held high for three instructions.
    nh = hs_q.size();
    r0 = m_ret;
    instr_valid = 1'b1;
    for (int i = 0; i < 4 * 3; i++) begin
      instr = $urandom;
      tick();
    end
    instr_valid = 1'b0;
    tick();
    chk("b2b_count", hs_q.size() - nh, 3);
    if (hs_q.size() - nh == 3) begin
      chk("b2b_gap1", hs_q[nh + 1] - hs_q[nh], 4);
      chk("b2b_gap2", hs_q[nh + 2] - hs_q[nh + 1], 4);
    end
    chk("b2b_retired", {16'd0, retired}, {16'd0, r0 + 16'd3});

    // Dual-write collision, then distinct destinations.
    ne = err_q.size();
    nw = wr_cyc_q.size();
    run_instr(mk(4'd5, 4'd5, 2'b11), h);
    chk("coll_err_cnt", err_q.size() - ne, 1);
    chk("coll_wr_cnt", wr_cyc_q.size() - nw, 1);
    if (err_q.size() > ne) chk("coll_err_cyc", err_q[ne], h + LAT + 1);
    if (wr_val_q.size() > nw) chk("coll_wr_val", {30'd0, wr_val_q[nw]}, 32'd1);
    ne = err_q.size();
    nw = wr_cyc_q.size();
    run_instr(mk(4'd5, 4'd6, 2'b11), h);
    chk("nocoll_err_cnt", err_q.size() - ne, 0);
    if (wr_val_q.size() > nw) chk("nocoll_wr_val", {30'd0, wr_val_q[nw]}, 32'd3);
    else chk("nocoll_wr_cnt", wr_cyc_q.size() - nw, 1);

    // Stall for three cycles starting in the second EXEC cycle.
    nw = wr_cyc_q.size();
    instr_valid = 1'b1; instr = mk(4'd1, 4'd2, 2'b01); h = cyc;
    tick();
    instr_valid = 1'b0;
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (3) tick();
    chk("stall_exec_wr_cnt", wr_cyc_q.size() - nw, 1);
    if (wr_cyc_q.size() > nw) chk("stall_exec_wb_cyc", wr_cyc_q[nw], h + LAT + 1 + 3);

    // Stall held across WB: exactly one write cycle once it drops.
    nw = wr_cyc_q.size();
    instr_valid = 1'b1; instr = mk(4'd3, 4'd4, 2'b10); h = cyc;
    tick();
    instr_valid = 1'b0;
    repeat (LAT) tick();
    stall = 1'b1;
    repeat (2) tick();
    stall = 1'b0;
    repeat (2) tick();
    chk("stall_wb_wr_cnt", wr_cyc_q.size() - nw, 1);
    if (wr_cyc_q.size() > nw) chk("stall_wb_cyc", wr_cyc_q[nw], h + LAT + 3);

    // A write field of 00 still retires.
    r0 = m_ret;
    run_instr(mk(4'd7, 4'd8, 2'b00), h);
    chk("wr00_retired", {16'd0, retired}, {16'd0, r0 + 16'd1});

    // Reset asserted in the first EXEC cycle aborts the instruction.
    nw = wr_cyc_q.size();
    instr_valid = 1'b1; instr = mk(4'd9, 4'd10, 2'b11);
    tick();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_write",   {30'd0, write}, 32'd0);
    chk("rst_fields",  {2'b00, fld_s}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_ready",   {31'd0, instr_ready}, 32'd0);
    model_reset();
    repeat (LAT + 2) tick();
    chk("rst_no_write", wr_cyc_q.size() - nw, 0);
    rst_n = 1'b1;
    run_instr(mk(4'd5, 4'd6, 2'b11), h);
    chk("post_rst_retired", {16'd0, retired}, 32'd1);

    // Retire counter wrap from 0xFFFF.
    force dut.retired_r = 16'hFFFF;
    #1;
    release dut.retired_r;
    m_ret = 16'hFFFF;
    run_instr(mk(4'd2, 4'd3, 2'b01), h);
    chk("wrap_retired", {16'd0, retired}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      instr_valid = ($urandom_range(1, 0) == 1);
      stall       = ($urandom_range(3, 0) == 0);
      if ($urandom_range(3, 0) == 0) instr = mk(4'd11, 4'd11, 2'b11);
      else instr = $urandom;
      tick();
    end
    instr_valid = 1'b0;
    stall = 1'b0;
    repeat (LAT + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
